// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Decoupling queue between the 2-wide IF stage and decode. IF pushes up to
//   two packets per beat (packet_a older), decode sees the two oldest entries
//   and pops 0, 1 or 2 of them per cycle. must_flush empties the queue.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   data_i          {packet_b, packet_a} from IF
//   pkt_valid_i     per-packet valid (01 or 11 legal)
//   valid_i         IF beat valid
//   ready_o         room for a full two-packet beat (registered count only)
//   must_flush      backend flush request
//   data_o          {slot1, slot0}, slot0 = head
//   valid_o         per-slot valid to decode
//   pop_i           decode consumes slots (00, 01, 11 legal)
//   count_o         current occupancy
//   protocol_err_o  sticky protocol-violation flag, cleared only by rst
module fetch_decode_queue #(
    parameter int PACKET_SIZE = 65,
    parameter int DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*PACKET_SIZE-1:0]   data_i,
    input  logic [1:0]                 pkt_valid_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       must_flush,
    output logic [2*PACKET_SIZE-1:0]   data_o,
    output logic [1:0]                 valid_o,
    input  logic [1:0]                 pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       protocol_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PACKET_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]          head, tail;
    logic [PW-1:0]          head1, tail1;
    logic [CW-1:0]          count;
    logic                   err;

    logic                   push;
    logic [CW-1:0]          push_n;
    logic [1:0]             pop_eff;
    logic [CW-1:0]          pop_n;
    logic                   bad;

    assign head1 = head + PW'(1);
    assign tail1 = tail + PW'(1);

    // ready only looks at the registered count: slots freed by a pop in this
    // cycle cannot be reused by a beat in the same cycle.
    assign ready_o = (count <= CW'(DEPTH - 2));
    assign valid_o = {count >= CW'(2), count >= CW'(1)};
    assign data_o  = {mem[head1], mem[head]};
    assign count_o = count;
    assign protocol_err_o = err;

    // A beat without packet_a valid is illegal and dropped outright.
    assign push    = valid_i & ready_o & ~must_flush & pkt_valid_i[0];
    assign push_n  = pkt_valid_i[1] ? CW'(2) : CW'(1);
    // Pop bits for slots that are not valid are masked off.
    assign pop_eff = pop_i & valid_o;
    assign pop_n   = CW'(pop_eff[0]) + CW'(pop_eff[1]);

    assign bad = (valid_i & ~pkt_valid_i[0])
               | (pop_i == 2'b10)
               | (|(pop_i & ~valid_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (bad) err <= 1'b1;
            if (must_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(pop_n);
                if (push) tail <= tail + PW'(push_n);
                count <= count + (push ? push_n : CW'(0)) - pop_n;
            end
        end
    end

    // Storage is not reset; slots are only meaningful under valid_o.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= data_i[PACKET_SIZE-1:0];
            if (pkt_valid_i[1]) mem[tail1] <= data_i[2*PACKET_SIZE-1:PACKET_SIZE];
        end
    end

    // Valid slots must hold their contents while nothing is consumed.
    a_slot0_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_o[0] && pop_i == 2'b00 && !must_flush) |=>
        (data_o[PACKET_SIZE-1:0] == $past(data_o[PACKET_SIZE-1:0])));
    a_slot1_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_o[1] && pop_i == 2'b00 && !must_flush) |=>
        (data_o[2*PACKET_SIZE-1:PACKET_SIZE] == $past(data_o[2*PACKET_SIZE-1:PACKET_SIZE])));
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));
    a_flush_empty: assert property (@(posedge clk) disable iff (rst)
        must_flush |=> valid_o == 2'b00);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized + directed bench for fetch_decode_queue. A queue-based model
// tracks the packets decode must see; a negedge process compares every cycle.
module tb_fetch_decode_queue;
    localparam int PS = 65;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*PS-1:0] data_i;
    logic [1:0]      pkt_valid_i;
    logic            valid_i;
    logic            ready_o;
    logic            must_flush;
    logic [2*PS-1:0] data_o;
    logic [1:0]      valid_o;
    logic [1:0]      pop_i;
    logic [3:0]      count_o;
    logic            protocol_err_o;

    fetch_decode_queue #(.PACKET_SIZE(PS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .pkt_valid_i(pkt_valid_i),
        .valid_i(valid_i), .ready_o(ready_o), .must_flush(must_flush),
        .data_o(data_o), .valid_o(valid_o), .pop_i(pop_i),
        .count_o(count_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit started = 0;

    logic [PS-1:0] mq[$];
    bit            merr;

    function automatic logic [PS-1:0] mk(logic [31:0] pc);
        return {pc, pc ^ 32'hdead_beef, pc[2]};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain FIFO of packets with the queue's acceptance rules.
    always @(posedge clk) begin
        int sz;
        logic [1:0] vo, pe;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            merr = 0;
        end else begin
            vo = {sz >= 2, sz >= 1};
            if ((valid_i && !pkt_valid_i[0]) || pop_i == 2'b10 || (pop_i & ~vo) != 0)
                merr = 1;
            if (must_flush) mq.delete();
            else begin
                pe = pop_i & vo;
                for (int i = 0; i < int'(pe[0]) + int'(pe[1]); i++) void'(mq.pop_front());
                if (valid_i && sz <= DEPTH - 2 && pkt_valid_i[0]) begin
                    mq.push_back(data_i[PS-1:0]);
                    if (pkt_valid_i[1]) mq.push_back(data_i[2*PS-1:PS]);
                end
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        if (started && !rst) begin
            sz = mq.size();
            check("count", 128'(count_o), 128'(sz));
            check("ready", 128'(ready_o), 128'(sz <= DEPTH - 2));
            check("valid", 128'(valid_o), 128'({sz >= 2, sz >= 1}));
            check("err", 128'(protocol_err_o), 128'(merr));
            if (sz >= 1) check("slot0", 128'(data_o[PS-1:0]), 128'(mq[0]));
            if (sz >= 2) check("slot1", 128'(data_o[2*PS-1:PS]), 128'(mq[1]));
        end
    end

    task automatic step(bit v, bit [1:0] pv, bit [31:0] pa, bit [31:0] pb,
                        bit [1:0] pop, bit fl);
        valid_i = v; pkt_valid_i = pv; data_i = {mk(pb), mk(pa)};
        pop_i = pop; must_flush = fl;
        @(posedge clk); #1;
        valid_i = 0; pop_i = 2'b00; must_flush = 0;
    endtask

    function automatic logic [31:0] pc0();
        return data_o[PS-1:PS-32];
    endfunction
    function automatic logic [31:0] pc1();
        return data_o[2*PS-1:2*PS-32];
    endfunction

    initial begin
        int sz, r, pc;
        bit v, fl, acc, hold;
        bit [1:0] hpv, pop;

        rst = 1; valid_i = 0; pkt_valid_i = 2'b01; data_i = '0;
        pop_i = 2'b00; must_flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        started = 1;
        check("rst_count", 128'(count_o), 0);
        check("rst_ready", 128'(ready_o), 1);
        check("rst_valid", 128'(valid_o), 0);
        check("rst_err", 128'(protocol_err_o), 0);

        // Fill with four two-packet beats.
        for (int k = 0; k < 4; k++) begin
            step(1, 2'b11, 8*k, 8*k + 4, 2'b00, 0);
            if (k == 2) begin
                check("fill3_count", 128'(count_o), 6);
                check("fill3_ready", 128'(ready_o), 1);
            end
        end
        check("full_count", 128'(count_o), 8);
        check("full_ready", 128'(ready_o), 0);
        check("full_pc0", 128'(pc0()), 0);
        check("full_pc1", 128'(pc1()), 4);
        step(1, 2'b11, 32'h100, 32'h104, 2'b00, 0);
        check("stall_count", 128'(count_o), 8);
        step(0, 2'b01, 0, 0, 2'b00, 1);
        check("flush_count", 128'(count_o), 0);

        // Fill with 0,4,8 then pop 01, 11.
        step(1, 2'b11, 0, 4, 2'b00, 0);
        step(1, 2'b01, 8, 0, 2'b00, 0);
        check("t2_count", 128'(count_o), 3);
        check("t2_pc0", 128'(pc0()), 0);
        step(0, 2'b01, 0, 0, 2'b01, 0);
        check("t2_count1", 128'(count_o), 2);
        check("t2_pc0b", 128'(pc0()), 4);
        check("t2_pc1b", 128'(pc1()), 8);
        step(0, 2'b01, 0, 0, 2'b11, 0);
        check("t2_count2", 128'(count_o), 0);
        check("t2_valid", 128'(valid_o), 0);

        // count=7 with simultaneous push and pop.
        for (int k = 0; k < 3; k++) step(1, 2'b11, 32'h200 + 8*k, 32'h204 + 8*k, 2'b00, 0);
        step(1, 2'b01, 32'h218, 0, 2'b00, 0);
        check("t4_count7", 128'(count_o), 7);
        check("t4_ready0", 128'(ready_o), 0);
        step(1, 2'b11, 32'h300, 32'h304, 2'b11, 0);
        check("t4_count5", 128'(count_o), 5);
        step(1, 2'b11, 32'h300, 32'h304, 2'b00, 0);
        check("t4_count7b", 128'(count_o), 7);

        // Flush overriding push and pop at count=5.
        step(0, 2'b01, 0, 0, 2'b11, 0);
        check("t5_count5", 128'(count_o), 5);
        step(1, 2'b11, 32'hAAA0, 32'hAAA4, 2'b11, 1);
        check("t5_count", 128'(count_o), 0);
        check("t5_valid", 128'(valid_o), 0);
        check("t5_ready", 128'(ready_o), 1);
        step(1, 2'b01, 32'h900, 0, 2'b00, 0);
        check("t5_pc0", 128'(pc0()), 32'h900);
        check("t5_count1", 128'(count_o), 1);
        step(0, 2'b01, 0, 0, 2'b00, 1);

        // Random traffic across pointer wrap with occasional flushes.
        pc = 32'h1000; hold = 0; hpv = 2'b01;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                hpv = $urandom_range(0, 1) ? 2'b11 : 2'b01;
            end
            sz = mq.size();
            r = $urandom_range(0, 2);
            pop = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            if (sz == 0) pop = 2'b00;
            else if (sz == 1 && pop == 2'b11) pop = 2'b01;
            fl = ($urandom_range(0, 39) == 0);
            acc = v && sz <= DEPTH - 2 && !fl;
            step(v, hpv, pc, pc + 4, pop, fl);
            hold = v && !acc && !fl;
            if (acc) pc += (hpv == 2'b11) ? 8 : 4;
        end
        check("rand_err", 128'(protocol_err_o), 0);

        // Illegal beat: error sets, count unchanged, sticky until rst.
        step(0, 2'b01, 0, 0, 2'b00, 1);
        step(1, 2'b01, 32'h40, 0, 2'b00, 0);
        step(1, 2'b10, 32'h50, 32'h54, 2'b00, 0);
        check("t6_err", 128'(protocol_err_o), 1);
        check("t6_count", 128'(count_o), 1);
        step(0, 2'b01, 0, 0, 2'b00, 1);
        repeat (3) step(0, 2'b01, 0, 0, 2'b00, 0);
        check("t6_err_held", 128'(protocol_err_o), 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        check("t6_err_clr", 128'(protocol_err_o), 0);
        step(0, 2'b01, 0, 0, 2'b10, 0);
        check("t6_pop10_err", 128'(protocol_err_o), 1);
        check("t6_pop10_count", 128'(count_o), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
